// File: rtl/bomb_pkg.sv
// Shared slot-state encoding, default timing constants and tile snapping
// for the bomb manager and its slots.
package bomb_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ARMED   = 2'd1,
    SLOT_PENDING = 2'd2
  } slot_state_t;

  localparam int FUSE_CYCLES_DEF = 400000000;
  localparam int TILE_SHIFT_DEF  = 4;

  // Round to the nearest tile origin; the sum wraps at coord_w bits.
  function automatic logic [31:0] snap(input logic [31:0] v, input int coord_w,
                                       input int tile_shift);
    logic [31:0] sum;
    sum = (v + (32'd1 << (tile_shift - 1))) & ((32'd1 << coord_w) - 32'd1);
    return (sum >> tile_shift) << tile_shift;
  endfunction

endpackage

// File: rtl/bomb_slot.sv
// One bomb slot: FREE/ARMED/PENDING state, tile origin and fuse timer.
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int COORD_W     = 10,
  parameter int TIMER_W     = 29,
  parameter int FUSE_CYCLES = FUSE_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               commit,
  input  logic               det_match,
  input  logic               pop,
  input  logic [COORD_W-1:0] new_x,
  input  logic [COORD_W-1:0] new_y,
  output logic [1:0]         state,
  output logic [COORD_W-1:0] org_x,
  output logic [COORD_W-1:0] org_y
);

  localparam logic [TIMER_W-1:0] LAST_TICK = TIMER_W'(FUSE_CYCLES - 1);

  slot_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      SLOT_FREE:    if (commit) state_d = SLOT_ARMED;
      SLOT_ARMED:   if (det_match || timer_q == LAST_TICK) state_d = SLOT_PENDING;
      SLOT_PENDING: if (pop) state_d = SLOT_FREE;
      default:      state_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SLOT_FREE;
      timer_q <= '0;
      org_x   <= '0;
      org_y   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SLOT_FREE && commit) begin
        timer_q <= '0;
        org_x   <= new_x;
        org_y   <= new_y;
      end else if (state_q == SLOT_ARMED) begin
        timer_q <= timer_q + TIMER_W'(1);
      end
    end
  end

  assign state = state_q;

endmodule

// File: rtl/bomb_manager.sv
// Multi-slot bomb manager: edge-detected placement with limits and duplicate
// rejection, forced detonation, expiry hand-off queue and registered pixel hit.
module bomb_manager
  import bomb_pkg::*;
#(
  parameter int NUM_SLOTS   = 6,
  parameter int FUSE_CYCLES = FUSE_CYCLES_DEF,
  parameter int TIMER_W     = 29,
  parameter int COORD_W     = 10,
  parameter int TILE_SHIFT  = TILE_SHIFT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    b_x,
  input  logic [COORD_W-1:0]    b_y,
  input  logic                  C,
  input  logic [3:0]            max_bombs,
  input  logic                  det_req,
  input  logic [COORD_W-1:0]    det_x,
  input  logic [COORD_W-1:0]    det_y,
  input  logic [COORD_W-1:0]    v_x,
  input  logic [COORD_W-1:0]    v_y,
  output logic                  bomb_on,
  output logic [COORD_W-1:0]    bomb_x,
  output logic [COORD_W-1:0]    bomb_y,
  output logic [TILE_SHIFT-1:0] sprite_row,
  output logic [TILE_SHIFT-1:0] sprite_col,
  output logic [3:0]            active_count,
  output logic                  place_ack,
  output logic                  place_reject,
  output logic                  exp_valid,
  output logic [COORD_W-1:0]    exp_x,
  output logic [COORD_W-1:0]    exp_y,
  input  logic                  exp_ready
);

  localparam logic [COORD_W:0] TILE_SZ = (COORD_W + 1)'(2 ** TILE_SHIFT);

  logic [1:0]           slot_st [NUM_SLOTS];
  logic [COORD_W-1:0]   slot_x  [NUM_SLOTS];
  logic [COORD_W-1:0]   slot_y  [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] free_oh, commit_oh, det_oh, pop_oh;
  logic                 c_q, rise, free_found, dup, accept;
  logic [COORD_W-1:0]   snap_x, snap_y;

  logic                  hit_p0;
  logic [COORD_W-1:0]    hit_x_p0, hit_y_p0, dx_p0, dy_p0;

  function automatic logic in_tile(input logic [COORD_W-1:0] v,
                                   input logic [COORD_W-1:0] o);
    return ({1'b0, v} >= {1'b0, o}) && ({1'b0, v} < {1'b0, o} + TILE_SZ);
  endfunction

  assign rise   = C & ~c_q;
  assign snap_x = COORD_W'(snap(32'(b_x), COORD_W, TILE_SHIFT));
  assign snap_y = COORD_W'(snap(32'(b_y), COORD_W, TILE_SHIFT));

  // Slot search, occupancy count and lowest-index expiry selection.
  always_comb begin
    free_oh      = '0;
    det_oh       = '0;
    pop_oh       = '0;
    free_found   = 1'b0;
    dup          = 1'b0;
    active_count = '0;
    exp_valid    = 1'b0;
    exp_x        = '0;
    exp_y        = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_st[i] == SLOT_FREE) begin
        if (!free_found) free_oh[i] = 1'b1;
        free_found = 1'b1;
      end else begin
        active_count = active_count + 4'd1;
        if (slot_x[i] == snap_x && slot_y[i] == snap_y) dup = 1'b1;
      end
      if (slot_st[i] == SLOT_PENDING && !exp_valid) begin
        exp_valid = 1'b1;
        exp_x     = slot_x[i];
        exp_y     = slot_y[i];
        pop_oh[i] = exp_ready;
      end
      det_oh[i] = det_req && slot_x[i] == det_x && slot_y[i] == det_y;
    end
    accept    = rise && free_found && !dup && (active_count < max_bombs);
    commit_oh = accept ? free_oh : '0;
  end

  // Pixel stage 0: lowest-index armed bomb covering the current pixel.
  always_comb begin
    hit_p0   = 1'b0;
    hit_x_p0 = '0;
    hit_y_p0 = '0;
    dx_p0    = '0;
    dy_p0    = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!hit_p0 && slot_st[i] == SLOT_ARMED &&
          in_tile(v_x, slot_x[i]) && in_tile(v_y, slot_y[i])) begin
        hit_p0   = 1'b1;
        hit_x_p0 = slot_x[i];
        hit_y_p0 = slot_y[i];
        dx_p0    = v_x - slot_x[i];
        dy_p0    = v_y - slot_y[i];
      end
    end
  end

  // Stage 1: registered placement pulses and pixel-hit outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_q          <= 1'b0;
      place_ack    <= 1'b0;
      place_reject <= 1'b0;
      bomb_on      <= 1'b0;
      bomb_x       <= '0;
      bomb_y       <= '0;
      sprite_col   <= '0;
      sprite_row   <= '0;
    end else begin
      c_q          <= C;
      place_ack    <= accept;
      place_reject <= rise && !accept;
      bomb_on      <= hit_p0;
      if (hit_p0) begin
        bomb_x     <= hit_x_p0;
        bomb_y     <= hit_y_p0;
        sprite_col <= dx_p0[TILE_SHIFT-1:0];
        sprite_row <= dy_p0[TILE_SHIFT-1:0];
      end
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bomb_slot #(
      .COORD_W    (COORD_W),
      .TIMER_W    (TIMER_W),
      .FUSE_CYCLES(FUSE_CYCLES)
    ) u_slot (
      .clk      (clk),
      .reset    (reset),
      .commit   (commit_oh[g]),
      .det_match(det_oh[g]),
      .pop      (pop_oh[g]),
      .new_x    (snap_x),
      .new_y    (snap_y),
      .state    (slot_st[g]),
      .org_x    (slot_x[g]),
      .org_y    (slot_y[g])
    );
  end

endmodule

// File: doc/bomb_manager.md
Name: bomb_manager

Overview:
- Parametrised successor to the single-player bomb block.
- Owns NUM_SLOTS bomb slots. Each slot has a fuse timer, a runtime bomb limit and tile-snapped placement, and duplicate-tile placements are rejected.
- Supports forced (chain) detonation.
- Expired bombs are reported to the explosion writer through a valid/ready queue, so simultaneous expiries are never lost.
- Also provides a registered pixel-hit path for the VGA renderer in the top module.

Parameters:
- NUM_SLOTS, 6: number of bomb slots (1..15).
- FUSE_CYCLES, 400000000: clocks from placement commit to expiry.
- TIMER_W, 29: fuse counter width; must satisfy 2^TIMER_W > FUSE_CYCLES.
- COORD_W, 10: pixel coordinate width.
- TILE_SHIFT, 4: log2 of tile and sprite size (16 px).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high game reset
- b_x, b_y  in  COORD_W each  player sprite top-left
- C  in  1  bomb button; level input, edge-detected internally
- max_bombs  in  4  runtime limit on live bombs; 0 blocks all placement
- det_req  in  1  force-detonate request from the explosion logic
- det_x, det_y  in  COORD_W each  tile-aligned coordinate to force-detonate
- v_x, v_y  in  COORD_W each  current pixel
- bomb_on  out  1  registered: previous pixel lies inside an ARMED bomb
- bomb_x, bomb_y  out  COORD_W each  registered origin of the hit bomb
- sprite_row, sprite_col  out  TILE_SHIFT each  registered offset of the pixel within the sprite
- active_count  out  4  number of ARMED plus PENDING slots
- place_ack  out  1  one-cycle pulse: placement accepted
- place_reject  out  1  one-cycle pulse: placement refused
- exp_valid  out  1  an expired bomb is awaiting hand-off
- exp_x, exp_y  out  COORD_W each  origin of the expired bomb
- exp_ready  in  1  explosion writer accepts the current exp_x/exp_y

Behaviour:
- Reset (synchronous, clk rising edge): all slots go FREE with timers at 0, the button history goes to 0, and every output is 0.
- Slot FSM has three states, FREE, ARMED and PENDING:
  - FREE -> ARMED: placement commit.
  - ARMED -> PENDING: when timer == FUSE_CYCLES-1, or on a det_req match.
  - PENDING -> FREE: on an exp_valid && exp_ready edge for that slot.
- Timer: increments by 1 per cycle only while ARMED and is cleared on commit. Expiry is therefore exactly FUSE_CYCLES cycles after the commit edge.
- Placement:
  - Cycle N: a rising edge is detected (C=1 with C_q=0); the placement is evaluated in cycle N using registered slot state.
  - Commit happens at edge N+1, together with a place_ack or place_reject pulse in cycle N+1.
  - Snapped position: x = ((b_x + 2^(TILE_SHIFT-1)) >> TILE_SHIFT) << TILE_SHIFT, computed in COORD_W bits with the carry dropped. y uses the same formula.
- Rejection occurs when any of the following holds:
  - active_count >= max_bombs;
  - no slot is FREE;
  - an ARMED or PENDING slot already sits at the same snapped tile.
- On acceptance, the lowest-index FREE slot is used.
- A held C produces exactly one attempt.
- Force-detonate: when det_req=1, every ARMED slot whose origin equals (det_x, det_y) goes PENDING at the next edge. det_req on a FREE or PENDING slot has no effect. Natural expiry and det_req in the same cycle give a single PENDING transition.
- Explosion queue:
  - exp_valid = OR of the PENDING flags.
  - exp_x/exp_y come from the lowest-index PENDING slot (combinational from registers).
  - Data is held stable until accepted.
  - Several PENDING slots drain one per accepted cycle, lowest index first.
  - exp_ready with exp_valid=0 is ignored.
- Same-cycle freeing: a slot freed by a handshake at edge N becomes usable for a placement evaluated in cycle N+1 or later, not in cycle N.
- active_count decrements on the hand-off, not on expiry.
- Pixel path, 1-cycle latency:
  - Hit test for each ARMED slot: origin <= v < origin + 2^TILE_SHIFT on both axes.
  - The lowest-index hit wins. bomb_x/bomb_y take the winner's origin, and sprite_col/sprite_row take the low TILE_SHIFT bits of v - origin.
  - With no hit: bomb_on=0, and bomb_x/bomb_y/sprite_col/sprite_row hold their previous values.
  - PENDING bombs are not drawn.
- Reset mid-operation: pending explosions are discarded and exp_valid drops in the cycle after the reset edge.

Decomposition:
- Package bomb_pkg: slot-state encoding (FREE=2'd0, ARMED=2'd1, PENDING=2'd2), the snap function, and the default FUSE_CYCLES and TILE_SHIFT constants.
- Sub-module bomb_slot: holds one slot's state, origin and timer, with inputs commit, det_match and pop. It is instantiated NUM_SLOTS times by generate.
- The parent holds the edge detect, free-slot/duplicate search, priority encoders and pixel path.

Test Plan (bench uses FUSE_CYCLES=100, NUM_SLOTS=6):
- Reset held, then released; pulse C with b_x=37, b_y=70 -> place_ack one cycle after the edge; slot 0 origin (32,64); exp_valid rises exactly 100 cycles after commit with exp_x=32, exp_y=64; active_count=1 until exp_ready, then 0.
- max_bombs=2; three placements at distinct tiles -> ack, ack, reject. A fourth placement at the first tile after it drains -> ack into slot 0.
- Two placements to the same tile ((40,40) snaps to (48,48), then (50,44)) -> ack, then reject with active_count=1. Holding C high for 20 cycles -> only one attempt.
- Three bombs committed in the same cycle window expire while exp_ready=0 -> exp_valid stays 1 with slot 0 data stable. exp_ready pulsed 3 times -> slots 0, 1, 2 drain in order, then exp_valid=0.
- Bomb at (64,64), timer at 10; det_req with (64,64) -> PENDING next cycle; det_req with (80,64) -> no change. Also: v=(64,64) -> bomb_on=1 and bomb_x=64 one cycle later; v=(80,64) -> bomb_on=0.
- Reset asserted while two slots are PENDING and one is ARMED -> the following cycle has exp_valid=0, active_count=0, bomb_on=0, and no place_ack.
